cpu_jtag_debug_cmd_driver: RTL and testbench

//  System-clock initiator for the CPU JTAG debug module. Turns one {IR, DR} command into the

---
 rtl/cpu_jtag_debug_cmd_driver_if.sv | 24 ++
 rtl/cpu_jtag_debug_cmd_driver.sv | 144 ++++++++++++++
 tb/tb_cpu_jtag_debug_cmd_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_jtag_debug_cmd_driver_if.sv
// Command/response handshake between a debug initiator and the JTAG command driver.
// The master side issues {IR, DR} commands; the slave side returns the captured DR word.
interface cpu_jtag_debug_cmd_driver_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cpu_jtag_debug_cmd_driver.sv
// System-clock virtual-JTAG initiator: plays one {IR, DR} command as UIR/CDR/SDR*N/UDR/RTI
// toward the debug module and returns the word shifted back on tdo.
module cpu_jtag_debug_cmd_driver #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  cpu_jtag_debug_cmd_driver_if.slave bus,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti,
  output logic                tdi,
  input  logic                tdo
);

  localparam int CNT_MAX = (DR_WIDTH > IDLE_GAP) ? DR_WIDTH : IDLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [DR_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                ir_known_q, ir_known_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                vs_uir_q, vs_uir_d;
  logic                vs_cdr_q, vs_cdr_d;
  logic                vs_sdr_q, vs_sdr_d;
  logic                vs_udr_q, vs_udr_d;
  logic                rti_q, rti_d;
  logic                tdi_q, tdi_d;
  logic                cmd_ready;

  // Only one response may be outstanding, so a pending rsp_valid blocks new commands.
  assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ir_in_d     = ir_in_q;
    ir_known_d  = ir_known_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          shreg_d = bus.cmd_data;
          // The IR is only re-shifted when it is unknown or actually changes.
          if (!ir_known_q || (bus.cmd_ir != ir_in_q)) begin
            state_d    = S_UIR;
            ir_in_d    = bus.cmd_ir;
            ir_known_d = 1'b1;
          end else begin
            state_d = S_CDR;
          end
        end
      end
      S_UIR: state_d = S_CDR;
      S_CDR: begin
        cnt_d   = CNT_W'(DR_WIDTH - 1);
        state_d = S_SDR;
      end
      S_SDR: begin
        shreg_d = {tdo, shreg_q[DR_WIDTH-1:1]};
        if (cnt_q == '0) state_d = S_UDR;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_UDR: begin
        rsp_data_d  = shreg_q;
        rsp_valid_d = 1'b1;
        cnt_d       = CNT_W'(IDLE_GAP - 1);
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered copies of the next-state decode so they line up with state_q.
    vs_uir_d = (state_d == S_UIR);
    vs_cdr_d = (state_d == S_CDR);
    vs_sdr_d = (state_d == S_SDR);
    vs_udr_d = (state_d == S_UDR);
    rti_d    = (state_d == S_IDLE) || (state_d == S_GAP);
    tdi_d    = (state_d == S_SDR) && shreg_d[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ir_in_q     <= '0;
      ir_known_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      vs_uir_q    <= 1'b0;
      vs_cdr_q    <= 1'b0;
      vs_sdr_q    <= 1'b0;
      vs_udr_q    <= 1'b0;
      rti_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ir_in_q     <= ir_in_d;
      ir_known_q  <= ir_known_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      vs_uir_q    <= vs_uir_d;
      vs_cdr_q    <= vs_cdr_d;
      vs_sdr_q    <= vs_sdr_d;
      vs_udr_q    <= vs_udr_d;
      rti_q       <= rti_d;
      tdi_q       <= tdi_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign ir_in           = ir_in_q;
  assign vs_uir          = vs_uir_q;
  assign vs_cdr          = vs_cdr_q;
  assign vs_sdr          = vs_sdr_q;
  assign vs_udr          = vs_udr_q;
  assign jtag_state_rti  = rti_q;
  assign tdi             = tdi_q;

endmodule

// File: tb/tb_cpu_jtag_debug_cmd_driver.sv
// Randomised bench for the JTAG command driver; expectations come from the sequence of bits
// the bench itself sends on tdo, the command data, and an IR-tracking model.
module tb_cpu_jtag_debug_cmd_driver;
  localparam int DW = 38;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [IW-1:0] ir_in;
  logic          vs_uir, vs_cdr, vs_sdr, vs_udr, rti, tdi;
  logic          tdo = 1'b0;

  cpu_jtag_debug_cmd_driver_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus ();

  cpu_jtag_debug_cmd_driver #(.DR_WIDTH(DW), .IR_WIDTH(IW), .IDLE_GAP(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .ir_in          (ir_in),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .jtag_state_rti (rti),
    .tdi            (tdi),
    .tdo            (tdo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // IR model: which instruction the debug module currently holds, if any.
  bit          m_known = 1'b0;
  logic [IW-1:0] m_ir  = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // mode: 0 random tdo, 1 tdo held high, 2 loopback (tdo = tdi of previous SDR cycle)
  task automatic do_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] data, input int mode,
                        input int abort_at, input int hold, output logic [DW-1:0] got_rsp);
    bit            exp_uir;
    int            wait_c, uir_c, cdr_c, rsp_c, nsdr, oh_err, herr;
    logic [DW-1:0] tdi_w, tdo_w;
    logic          prev_tdi;
    got_rsp = '0;
    exp_uir = !m_known || (ir != m_ir);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_ir = ir; bus.cmd_data = data;
    wait_c = 0;
    while (!bus.cmd_ready && wait_c < 100) begin @(negedge clk); wait_c++; end
    chk("accept_timeout", 64'(wait_c < 100), 64'd1);
    if (wait_c >= 100) begin bus.cmd_valid = 1'b0; return; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ir    = IW'($urandom);
    bus.cmd_data  = {6'($urandom), 32'($urandom)};
    m_known = 1'b1; m_ir = ir;
    uir_c = -1; cdr_c = -1; rsp_c = -1; nsdr = 0; oh_err = 0;
    tdi_w = '0; tdo_w = '0; prev_tdi = 1'b0;
    for (int c = 1; c <= 100 && rsp_c < 0; c++) begin
      @(negedge clk);
      if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr, rti}) > 1) oh_err++;
      if (vs_uir && uir_c < 0) uir_c = c;
      if (vs_cdr && cdr_c < 0) cdr_c = c;
      if (bus.rsp_valid) rsp_c = c;
      if (vs_sdr) begin
        if (nsdr == abort_at) begin
          reset_n = 1'b0; #1;
          chk("abort_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, tdi}), 64'd0);
          chk("abort_rti", 64'(rti), 64'd1);
          chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
          m_known = 1'b0;
          @(negedge clk); reset_n = 1'b1;
          repeat (45) @(negedge clk);
          chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
          return;
        end
        if (nsdr < DW) begin
          tdi_w[nsdr] = tdi;
          tdo = (mode == 1) ? 1'b1 : (mode == 2) ? prev_tdi : 1'($urandom);
          tdo_w[nsdr] = tdo;
        end
        prev_tdi = tdi;
        nsdr++;
      end
    end
    chk("uir_cycle", 64'(uir_c), exp_uir ? 64'd1 : 64'(-1));
    chk("cdr_cycle", 64'(cdr_c), exp_uir ? 64'd2 : 64'd1);
    chk("sdr_count", 64'(nsdr), 64'(DW));
    chk("rsp_cycle", 64'(rsp_c), exp_uir ? 64'(DW + 4) : 64'(DW + 3));
    chk("tdi_bits", 64'(tdi_w), 64'(data));
    chk("rsp_data", 64'(bus.rsp_data), 64'(tdo_w));
    chk("onehot", 64'(oh_err), 64'd0);
    chk("ir_in", 64'(ir_in), 64'(ir));
    got_rsp = bus.rsp_data;
    if (hold > 0) begin
      herr = 0;
      bus.cmd_valid = 1'b1; bus.cmd_data = {6'($urandom), 32'($urandom)};
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (bus.cmd_ready || bus.rsp_data !== got_rsp || !bus.rsp_valid) herr++;
      end
      chk("hold_stall", 64'(herr), 64'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1; bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("hold_rsp_drop", 64'(bus.rsp_valid), 64'd0);
      chk("hold_ready_back", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1; bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    end
  endtask

  initial begin
    logic [DW-1:0] rsp, d;
    logic [IW-1:0] ir;
    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_ir_in", 64'(ir_in), 64'd0);
    chk("rst_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, tdi}), 64'd0);
    chk("rst_rti", 64'(rti), 64'd1);
    reset_n = 1'b1;

    do_cmd(2'b01, 38'h00_0000_0001, 1, -1, 0, rsp);
    chk("t1_all_ones", 64'(rsp), 64'h3F_FFFF_FFFF);

    do_cmd(2'b10, {6'($urandom), 32'($urandom)}, 0, -1, 0, rsp);
    do_cmd(2'b10, {6'($urandom), 32'($urandom)}, 0, -1, 0, rsp);

    d = 38'h2A_AAAA_AAAA;
    do_cmd(2'b10, d, 2, -1, 0, rsp);
    chk("t3_loopback", 64'(rsp), 64'({d[DW-2:0], 1'b0}));

    do_cmd(2'b11, {6'($urandom), 32'($urandom)}, 0, -1, 10, rsp);

    do_cmd(2'b11, {6'($urandom), 32'($urandom)}, 0, 20, 0, rsp);
    do_cmd(2'b11, {6'($urandom), 32'($urandom)}, 0, -1, 0, rsp);

    ir = 2'b00;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) ir = IW'($urandom);
      do_cmd(ir, {6'($urandom), 32'($urandom)}, 0, -1, 0, rsp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
